// File: rtl/eb2_skid.sv
// Two-entry elastic buffer; forward (i_valid/i_data) and backward (t_ready) paths both registered.
// Latency: one cycle from upstream acceptance to i_data when EMPTY or draining; 1 word/cycle sustained.
// Backpressure: t_ready drops only when both entries are held; it comes from a flop, never from i_ready.
//
// Ports:
//   clk             clock, rising edge
//   rstf            asynchronous reset, active low
//   t_data/t_valid  upstream payload and valid
//   t_ready         buffer can accept (registered)
//   i_data/i_valid  downstream payload and valid (registered)
//   i_ready         downstream accepts
//   count           occupancy 0..2 (registered)
module eb2_skid #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rstf,
    input  logic [DWIDTH-1:0] t_data,
    input  logic              t_valid,
    output logic              t_ready,
    output logic [DWIDTH-1:0] i_data,
    output logic              i_valid,
    input  logic              i_ready,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] main_q, main_d;
    logic [DWIDTH-1:0] skid_q, skid_d;
    logic              t_ready_q, t_ready_d;
    logic              i_valid_q, i_valid_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                // i_valid is low here, so i_ready has no effect.
                if (t_valid) begin
                    state_d = ST_HALF;
                    main_d  = t_data;
                end
            end
            ST_HALF: begin
                if (t_valid && i_ready) begin
                    main_d = t_data;
                end else if (t_valid) begin
                    // Downstream stalled: park the new word behind main.
                    state_d = ST_FULL;
                    skid_d  = t_data;
                end else if (i_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // t_ready is low, so upstream inputs are ignored entirely.
                if (i_ready) begin
                    state_d = ST_HALF;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Outputs are decoded from the next state so they can be flopped
        // alongside it, keeping every output a pure register.
        t_ready_d = (state_d != ST_FULL);
        i_valid_d = (state_d != ST_EMPTY);
        count_d   = 2'd0;
        case (state_d)
            ST_HALF: count_d = 2'd1;
            ST_FULL: count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            t_ready_q <= 1'b1;
            i_valid_q <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            t_ready_q <= t_ready_d;
            i_valid_q <= i_valid_d;
            count_q   <= count_d;
        end
    end

    assign t_ready = t_ready_q;
    assign i_valid = i_valid_q;
    assign i_data  = main_q;
    assign count   = count_q;

`ifdef FORMAL
    a_count_range : assert property (@(posedge clk) disable iff (!rstf)
        count != 2'd3);
    a_ready_dec : assert property (@(posedge clk) disable iff (!rstf)
        t_ready == (count != 2'd2));
    a_valid_dec : assert property (@(posedge clk) disable iff (!rstf)
        i_valid == (count != 2'd0));
    a_hold : assert property (@(posedge clk) disable iff (!rstf)
        $past(i_valid && !i_ready) |-> (i_valid && $stable(i_data)));
    a_full_entry : assert property (@(posedge clk) disable iff (!rstf)
        (count == 2'd2 && $past(count != 2'd2)) |->
            $past(count == 2'd1 && t_valid && !i_ready));
    a_reset_vals : assert property (@(posedge clk)
        !rstf |-> (count == 2'd0 && !i_valid && t_ready && i_data == '0));
`endif

endmodule

// File: tb/tb_eb2_skid.sv
// Self-checking bench for eb2_skid: directed scenarios with literal expectations
// plus a long randomized run compared every cycle against a queue-based model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_eb2_skid;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstf;
    logic [DW-1:0] t_data;
    logic          t_valid;
    logic          t_ready;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          i_ready;
    logic [1:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    eb2_skid #(.DWIDTH(DW)) dut (
        .clk     (clk),
        .rstf    (rstf),
        .t_data  (t_data),
        .t_valid (t_valid),
        .t_ready (t_ready),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a FIFO of capacity two. The buffer accepts whenever
    // fewer than two words are held and presents the oldest word downstream.
    logic [DW-1:0] m_q[$];
    bit            m_zero = 1'b1;  // nothing pushed since reset: i_data must read 0
    bit            m_dn, m_up;

    always @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            m_q.delete();
            m_zero = 1'b1;
        end else begin
            m_dn = (m_q.size() > 0) && i_ready;
            m_up = t_valid && (m_q.size() < 2);
            if (m_dn) void'(m_q.pop_front());
            if (m_up) begin
                m_q.push_back(t_data);
                m_zero = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rstf === 1'b1) begin
            chk("m_t_ready", {31'd0, t_ready}, {31'd0, m_q.size() < 2});
            chk("m_i_valid", {31'd0, i_valid}, {31'd0, m_q.size() > 0});
            chk("m_count", {30'd0, count}, m_q.size());
            if (m_q.size() > 0)
                chk("m_i_data", i_data, m_q[0]);
            else if (m_zero)
                chk("m_i_data_rst", i_data, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_i_valid"}, {31'd0, i_valid}, 32'd0);
        chk({tag, "_t_ready"}, {31'd0, t_ready}, 32'd1);
        chk({tag, "_count"}, {30'd0, count}, 32'd0);
        chk({tag, "_i_data"}, i_data, 32'd0);
    endtask

    logic tr_snap;

    initial begin
        rstf    = 1'b0;
        t_valid = 1'b0;
        t_data  = '0;
        i_ready = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            t_valid = 1'($urandom);
            t_data  = $urandom;
            i_ready = 1'($urandom);
            @(negedge clk);
            chk_reset_vals("rst_hold");
        end
        @(posedge clk);
        #1;
        rstf    = 1'b1;
        t_valid = 1'b1;
        t_data  = 32'h5;
        i_ready = 1'b0;
        step();
        chk("first_push_data", i_data, 32'h5);
        chk("first_push_valid", {31'd0, i_valid}, 32'd1);
        chk("first_push_count", {30'd0, count}, 32'd1);
        t_valid = 1'b0;
        i_ready = 1'b1;
        step();
        chk("first_drain_count", {30'd0, count}, 32'd0);

        // Streaming with simultaneous accept and drain.
        i_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            t_valid = 1'b1;
            t_data  = k;
            step();
            chk("stream_data", i_data, k);
            chk("stream_t_ready", {31'd0, t_ready}, 32'd1);
            chk("stream_count", {30'd0, count}, 32'd1);
        end
        t_valid = 1'b0;
        step();
        chk("stream_end_count", {30'd0, count}, 32'd0);

        // Backpressure: fill, ignore a third word, then drain in order.
        i_ready = 1'b0;
        t_valid = 1'b1;
        t_data  = 32'hA;
        step();
        t_data  = 32'hB;
        step();
        chk("bp_full_count", {30'd0, count}, 32'd2);
        chk("bp_full_t_ready", {31'd0, t_ready}, 32'd0);
        chk("bp_full_data", i_data, 32'hA);
        t_data = 32'hC;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_stall_count", {30'd0, count}, 32'd2);
            chk("bp_stall_data", i_data, 32'hA);
        end
        i_ready = 1'b1;
        step();
        chk("bp_drain1_data", i_data, 32'hB);
        chk("bp_drain1_t_ready", {31'd0, t_ready}, 32'd1);
        chk("bp_drain1_count", {30'd0, count}, 32'd1);
        step();
        chk("bp_drain2_data", i_data, 32'hC);
        chk("bp_drain2_count", {30'd0, count}, 32'd1);
        t_valid = 1'b0;
        step();
        chk("bp_empty_count", {30'd0, count}, 32'd0);

        // Asynchronous reset while FULL, asserted and released between edges.
        i_ready = 1'b0;
        t_valid = 1'b1;
        t_data  = 32'h11;
        step();
        t_data  = 32'h22;
        step();
        chk("arst_pre_count", {30'd0, count}, 32'd2);
        t_valid = 1'b0;
        #1;
        rstf = 1'b0;
        #1;
        chk_reset_vals("arst_mid");
        #1;
        rstf = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        t_valid = 1'b1;
        t_data  = 32'h33;
        step();
        chk("arst_after_data", i_data, 32'h33);
        chk("arst_after_count", {30'd0, count}, 32'd1);
        t_valid = 1'b0;
        step();
        chk("arst_after_empty", {30'd0, count}, 32'd0);
        chk("arst_after_valid", {31'd0, i_valid}, 32'd0);

        // Randomized traffic against the model, with occasional mid-cycle
        // i_ready glitches that must not reach t_ready.
        for (int n = 0; n < 10000; n++) begin
            t_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            t_data  = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                tr_snap = t_ready;
                i_ready = ~i_ready;
                #1;
                i_ready = ~i_ready;
                #1;
                chk("t_ready_glitch", {31'd0, t_ready}, {31'd0, tr_snap});
            end
            step();
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
